// File: rtl/imm_pkg.sv
// Shared immediate-format codes and default datapath width for the decode stage.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for RV32/RV64 base formats.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // Every format is first built as a 32-bit value; Z keeps bit 31 clear so the
  // common sign-extension to XLEN becomes a zero-extension for it.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: imm_decode followed by a valid/ready slice
// with optional skid entry so in_ready never depends combinationally on out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q,   main_imm_d;
  logic            main_ill_q,   main_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic            skid_ill_q,   skid_ill_d;

  logic            in_xfer;
  logic            main_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign main_free = !main_valid_q || out_ready;
  assign in_ready  = SKID ? !skid_valid_q : main_free;
  assign in_xfer   = in_valid && in_ready;

  // With SKID=1 in_ready is low whenever the skid entry is full, so a refill of
  // main from skid never coincides with a new input being accepted.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) begin
          main_imm_d = dec_imm;
          main_ill_d = dec_ill;
        end
      end
    end else if (in_xfer && SKID) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid = main_valid_q;
  assign imm_ext   = main_imm_q;
  assign illegal   = main_ill_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It extracts and extends the immediate for every RV32/RV64 base format (I, S, B, U, J) plus the CSR zero-extended immediate. The result goes into a two-entry valid/ready register slice that sits between decode and execute. The slice supports back-pressure and pipeline flush without combinational ready paths.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64
- SKID, 1, 1 = two-entry slice with registered in_ready; 0 = single entry with in_ready = !out_valid || out_ready

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard all held entries; synchronous
- in_valid  input  1  instruction presented
- in_ready  output  1  slice can accept this cycle
- instr  input  32  raw instruction word
- imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110/111 reserved
- out_valid  output  1  imm_ext/illegal valid
- out_ready  input  1  downstream accepts
- imm_ext  output  XLEN  extended immediate
- illegal  output  1  imm_src was a reserved code

## Operation
Format rules (sext = sign-extend from the top listed bit to XLEN):
- I: sext(instr[31:20])
- S: sext({instr[31:25], instr[11:7]})
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
- U: sext({instr[31:12], 12'b0}); with XLEN=64, bits 63:32 copy bit 31
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
- Z: zero-extend instr[19:15]
- 110/111: imm_ext = 0, illegal = 1. The entry still flows normally and is not dropped.

Slice behaviour:
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- The main entry drives the outputs. With SKID=1, an input accepted while the main entry is stalled goes into the skid entry.
- When the main entry drains, the skid entry moves into it. Order is strictly FIFO.
- With SKID=1, in_ready = !skid_valid and is registered.
- While out_valid && !out_ready, imm_ext and illegal hold stable.
- flush has priority over everything:
  - both entries are invalidated at the next edge;
  - an input accepted in the same cycle is discarded;
  - in_ready is 1 in the following cycle.

## Timing
- Latency: 1 cycle. An entry accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 per cycle when out_ready is held high.
- Simultaneous in and out transfer with a full main entry and empty skid entry: the new data replaces the main entry. The skid entry is not used.
- With SKID=1, a stall needs two accepted inputs before in_ready drops to 0, one cycle after the second accept.
- Reset (rst_n low, asynchronous) sets:
  - out_valid = 0, imm_ext = 0, illegal = 0;
  - skid entry invalid and zero;
  - in_ready = 1.
- Reset asserted mid-stall drops all entries immediately. There is no transfer in the first cycle after release unless in_valid is high.
- Outputs depend only on registers. There is no combinational path from in_* to out_*.

## Structure
- Shared package imm_pkg holds:
  - the imm_src code constants (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z);
  - the default XLEN.
- Sub-module imm_decode is purely combinational: (instr, imm_src) -> (imm, illegal), parametrised on XLEN.
- imm_gen_pipe instantiates imm_decode and implements the register slice around it.

## Test plan
- I-type 0xFFF00093 (addi x1,x0,-1), imm_src=000 -> one cycle later out_valid=1, imm_ext=0xFFFFFFFF, illegal=0.
- S-type 0xFE20AE23 (sw x2,-4(x1)) -> 0xFFFFFFFC. B-type 0xFE000CE3 (beq -8) -> 0xFFFFFFF8. J-type 0x0010006F (jal +2048) -> 0x00000800.
- XLEN=64, U-type 0x800002B7 (lui x5,0x80000) -> 0xFFFFFFFF80000000. Z-type with instr[19:15]=5'h1F -> 0x1F.
- SKID=1, out_ready=0 for 3 cycles, 3 back-to-back inputs A,B,C:
  - A and B are accepted; in_ready=0 while C waits;
  - outputs hold A;
  - after out_ready=1 the outputs show A, B, C in order with none lost.
- Stalled with two entries, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- imm_src=110 -> imm_ext=0, illegal=1, out_valid=1. Asserting rst_n=0 mid-stall clears out_valid within the same cycle.
